button_conditioner: RTL and testbench

//  Turns a raw asynchronous push-button input into a clean single-cycle trigger pulse B and a debounced level Pressed.

---
 rtl/button_conditioner_pkg.sv | 15 +
 rtl/button_conditioner_sync_2ff.sv | 22 ++
 rtl/button_conditioner.sv | 111 +++++++++++
 tb/tb_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioning chain:
// default debounce parameters and the debounce FSM state encoding.
package button_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 4;

  typedef enum logic [1:0] {
    S_Idle      = 2'd0,
    S_PressWait = 2'd1,
    S_Held      = 2'd2,
    S_RelWait   = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: Clk, Rst (sync, active-high), D (async in), Q (synced out).
module sync_2ff (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Q
);

  logic ff1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ff1 <= 1'b0;
      Q   <= 1'b0;
    end else begin
      ff1 <= D;
      Q   <= ff1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Raw button -> synchronizer -> debounce FSM -> one-shot press pulse.
// Ports: Clk, Rst (sync, active-high), BtnRaw in; B pulse, Pressed level out.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnRaw,
  output logic B,
  output logic Pressed
);

  if (DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("button_conditioner: bad DEBOUNCE_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  btn_state_t       state;
  btn_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             press_ok;
  logic             rel_ok;
  logic             b_n;
  logic             pressed_n;

  sync_2ff u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .D   (BtnRaw),
    .Q   (btn_sync)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_Idle;
      cnt     <= '0;
      B       <= 1'b0;
      Pressed <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      B       <= b_n;
      Pressed <= pressed_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    press_ok = 1'b0;
    rel_ok   = 1'b0;
    case (state)
      S_Idle: begin
        if (btn_sync) begin
          state_n = S_PressWait;
          cnt_n   = '0;
        end
      end
      S_PressWait: begin
        if (!btn_sync) begin
          state_n = S_Idle;
        end else if (cnt == CNT_LAST) begin
          state_n  = S_Held;
          press_ok = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_Held: begin
        if (!btn_sync) begin
          state_n = S_RelWait;
          cnt_n   = '0;
        end
      end
      S_RelWait: begin
        if (btn_sync) begin
          state_n = S_Held;
        end else if (cnt == CNT_LAST) begin
          state_n = S_Idle;
          rel_ok  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_Idle;
        cnt_n   = '0;
      end
    endcase
  end

  // B is a one-shot: only the accepting transition raises it.
  always_comb begin
    b_n       = press_ok;
    pressed_n = Pressed;
    unique case (1'b1)
      press_ok: pressed_n = 1'b1;
      rel_ok:   pressed_n = 1'b0;
      default:  pressed_n = Pressed;
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: two DUTs (4 and 1 debounce cycles) share stimulus
// and are compared every cycle against a run-length debounce model.
module tb_button_conditioner;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic BtnRaw = 1'b0;
  logic B4, P4, B1, P1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;

  button_conditioner u4 (
    .Clk     (Clk),
    .Rst     (Rst),
    .BtnRaw  (BtnRaw),
    .B       (B4),
    .Pressed (P4)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(1)) u1 (
    .Clk     (Clk),
    .Rst     (Rst),
    .BtnRaw  (BtnRaw),
    .B       (B1),
    .Pressed (P1)
  );

  // Model: the debounced level flips once the synchronized input has
  // disagreed with it for D+1 consecutive edges; B marks a 0->1 flip.
  int   dc [2] = '{4, 1};
  logic q1 [2];
  logic q2 [2];
  logic lv [2];
  logic eb [2];
  int   run [2];

  function automatic logic [3:0] exp_v();
    return {eb[0], lv[0], eb[1], lv[1]};
  endfunction

  task automatic tick(input logic r, input logic v);
    logic s;
    Rst = r;
    BtnRaw = v;
    @(posedge Clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        q1[k] = 0; q2[k] = 0; lv[k] = 0;
        eb[k] = 0; run[k] = 0;
      end else begin
        s = q2[k];
        q2[k] = q1[k];
        q1[k] = v;
        eb[k] = 0;
        if (s != lv[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == dc[k] + 1) begin
          lv[k] = ~lv[k];
          eb[k] = lv[k];
          run[k] = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if ({B4, P4, B1, P1} !== 4'b0000) begin
        errors++;
        $display("FAIL reset act=%b exp=0000 cyc=%0d",
                 {B4, P4, B1, P1}, cyc);
      end
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL settle act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
  endtask

  task automatic test_clean_press();
    int rise = -1;
    int np = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1);
      if (B4) begin np++; if (rise < 0) rise = i; end
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL press act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
    checks++;
    if (rise !== 6) begin
      errors++;
      $display("FAIL press_edge act=%0d exp=6", rise);
    end
    checks++;
    if (np !== 1 || P4 !== 1'b1) begin
      errors++;
      $display("FAIL press_count act=%0d/%b exp=1/1", np, P4);
    end
  endtask

  task automatic test_release();
    int fall = -1;
    int np = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b0);
      if (B4) np++;
      if (!P4 && fall < 0) fall = i;
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL release act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
    checks++;
    if (fall !== 6 || np !== 0) begin
      errors++;
      $display("FAIL release_edge act=%0d/%0d exp=6/0", fall, np);
    end
  endtask

  task automatic test_press_bounce();
    logic [6:0] pat = 7'b1101011;
    int np = 0;
    int hp = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1'b0, i < 7 ? pat[6-i] : 1'b0);
      if (B4) np++;
      if (P4) hp++;
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL bounce act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
    checks++;
    if (np !== 0 || hp !== 0) begin
      errors++;
      $display("FAIL bounce_out act=%0d/%0d exp=0/0", np, hp);
    end
  endtask

  task automatic test_release_bounce();
    int np = 0;
    int lo = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, !(i == 12 || i == 13));
      if (B4 && i > 6) np++;
      if (!P4 && i >= 6) lo++;
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL relbounce act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
    checks++;
    if (np !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL relbounce_out act=%0d/%0d exp=0/0", np, lo);
    end
  endtask

  task automatic test_reset_mid();
    int pre = 0;
    int r4 = -1;
    int r1 = -1;
    int np = 0;
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, 1'b1);
      if (B4) pre++;
    end
    checks++;
    if (pre !== 0 || {B4, P4, B1, P1} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_pre act=%0d/%b exp=0/0000",
               pre, {B4, P4, B1, P1});
    end
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 1'b1);
      if (B4) begin np++; if (r4 < 0) r4 = i; end
      if (B1 && r1 < 0) r1 = i;
      checks++;
      if ({B4, P4, B1, P1} !== exp_v()) begin
        errors++;
        $display("FAIL rstmid act=%b exp=%b cyc=%0d",
                 {B4, P4, B1, P1}, exp_v(), cyc);
      end
    end
    checks++;
    if (r4 !== 6 || r1 !== 3 || np !== 1) begin
      errors++;
      $display("FAIL rstmid_edge act=%0d/%0d/%0d exp=6/3/1",
               r4, r1, np);
    end
  endtask

  task automatic test_random();
    logic v;
    int len;
    for (int s = 0; s < 400; s++) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        tick($urandom_range(0, 59) == 0, v);
        checks++;
        if ({B4, P4, B1, P1} !== exp_v()) begin
          errors++;
          $display("FAIL random act=%b exp=%b cyc=%0d",
                   {B4, P4, B1, P1}, exp_v(), cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    settle();
    test_clean_press();
    test_release();
    settle();
    test_press_bounce();
    settle();
    test_release_bounce();
    settle();
    test_reset_mid();
    settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
